// File: rtl/fuel_refill_controller.sv
// fuel_refill_controller: pumps a refill one litre at a time and clips delivery at tank capacity
module fuel_refill_controller #(
  parameter int TANK_CAP     = 31,
  parameter int PULSE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [4:0] req_litres,
  input  logic       abort,
  input  logic [4:0] tank_level_in,
  output logic       busy,
  output logic       pump_on,
  output logic       litre_pulse,
  output logic [4:0] tank_level,
  output logic [4:0] delivered,
  output logic       done,
  output logic       clipped
);
  localparam int CW = PULSE_CYCLES > 1 ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(PULSE_CYCLES - 1);
  localparam logic [4:0] CAP = 5'(TANK_CAP);
  localparam logic [1:0] IDLE = 2'd0, PUMP = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [4:0] remaining, room, target;
  // free capacity and the clipped delivery target for a new request
  always_comb begin
    room = tank_level_in >= CAP ? 5'd0 : CAP - tank_level_in;
    target = req_litres > room ? room : req_litres;
  end
  assign busy = state != IDLE;
  assign pump_on = state == PUMP;
  assign done = state == DONE;
  // refill sequencing: accept request, count pump cycles per litre, finish or abort
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      remaining <= '0;
      tank_level <= '0;
      delivered <= '0;
      clipped <= 1'b0;
      litre_pulse <= 1'b0;
    end else begin
      litre_pulse <= 1'b0;
      case (state)
        IDLE: if (start) begin
          tank_level <= tank_level_in;
          delivered <= '0;
          clipped <= req_litres > room;
          remaining <= target;
          cnt <= RELOAD;
          state <= target == 5'd0 ? DONE : PUMP;
        end
        PUMP: if (cnt == '0) begin
          litre_pulse <= 1'b1;
          tank_level <= tank_level + 5'd1;
          delivered <= delivered + 5'd1;
          remaining <= remaining - 5'd1;
          cnt <= RELOAD;
          if (remaining == 5'd1 || abort) state <= DONE;
        end else begin
          cnt <= cnt - 1'b1;
          if (abort) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fuel_refill_controller.sv
// tb_fuel_refill_controller: table-driven refill scenarios plus reset-mid-pump sequence
module tb_fuel_refill_controller;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0;
  logic [4:0] req_litres = '0, tank_level_in = '0;
  logic busy, pump_on, litre_pulse, done, clipped;
  logic [4:0] tank_level, delivered;
  int n_vec = 0, n_bad = 0;

  fuel_refill_controller #(.TANK_CAP(31), .PULSE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .start(start), .req_litres(req_litres), .abort(abort),
    .tank_level_in(tank_level_in), .busy(busy), .pump_on(pump_on), .litre_pulse(litre_pulse),
    .tank_level(tank_level), .delivered(delivered), .done(done), .clipped(clipped)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int level_in, req, abort_edge, restart_edge;
    int pulses, done_edge, level, deliv, clip, pump_seen;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v);
    int k = 0, pulses = 0, pump_seen = 0, done_edge = -1;
    @(negedge clk);
    tank_level_in = 5'(v.level_in);
    req_litres = 5'(v.req);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    forever begin
      pulses += int'(litre_pulse);
      pump_seen |= int'(pump_on);
      if (done) begin
        done_edge = k;
        break;
      end
      if (k >= 200) break;
      abort = v.abort_edge != 0 && k + 1 == v.abort_edge;
      start = v.restart_edge != 0 && k + 1 == v.restart_edge;
      if (start) req_litres = 5'd9;
      @(posedge clk);
      k++;
      #1 abort = 1'b0;
      start = 1'b0;
    end
    chk({v.name, " done_edge"}, done_edge, v.done_edge);
    chk({v.name, " pulses"}, pulses, v.pulses);
    chk({v.name, " pump_seen"}, pump_seen, v.pump_seen);
    chk({v.name, " tank_level"}, int'(tank_level), v.level);
    chk({v.name, " delivered"}, int'(delivered), v.deliv);
    chk({v.name, " clipped"}, int'(clipped), v.clip);
    chk({v.name, " busy_at_done"}, int'(busy), 1);
    @(posedge clk);
    #1;
    chk({v.name, " done_one_cycle"}, int'(done), 0);
    chk({v.name, " idle"}, int'(busy), 0);
    chk({v.name, " hold_level"}, int'(tank_level), v.level);
    chk({v.name, " hold_deliv"}, int'(delivered), v.deliv);
    chk({v.name, " hold_clip"}, int'(clipped), v.clip);
  endtask

  initial begin
    vec_t vecs[8];
    int seen_done;
    vecs[0] = '{"nominal",      10, 3, 0, 0, 3, 12, 13, 3, 0, 1};
    vecs[1] = '{"clip",         29, 5, 0, 0, 2,  8, 31, 2, 1, 1};
    vecs[2] = '{"full_tank",    31, 4, 0, 0, 0,  0, 31, 0, 1, 0};
    vecs[3] = '{"zero_req",     10, 0, 0, 0, 0,  0, 10, 0, 0, 0};
    vecs[4] = '{"abort_mid",     0, 5, 6, 0, 1,  6,  1, 1, 0, 1};
    vecs[5] = '{"abort_on_litre",0, 5, 8, 0, 2,  8,  2, 2, 0, 1};
    vecs[6] = '{"exact_room",   25, 6, 0, 0, 6, 24, 31, 6, 0, 1};
    vecs[7] = '{"start_busy",   10, 3, 0, 3, 3, 12, 13, 3, 0, 1};
    #1;
    chk("reset busy", int'(busy), 0);
    chk("reset tank_level", int'(tank_level), 0);
    chk("reset done", int'(done), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    foreach (vecs[i]) run(vecs[i]);
    @(negedge clk);
    tank_level_in = 5'd0;
    req_litres = 5'd5;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid busy", int'(busy), 0);
    chk("rst_mid pump_on", int'(pump_on), 0);
    chk("rst_mid litre_pulse", int'(litre_pulse), 0);
    chk("rst_mid tank_level", int'(tank_level), 0);
    chk("rst_mid delivered", int'(delivered), 0);
    chk("rst_mid clipped", int'(clipped), 0);
    seen_done = int'(done);
    repeat (3) begin
      @(posedge clk);
      #1 seen_done |= int'(done);
    end
    @(negedge clk) reset = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1 seen_done |= int'(done);
    end
    chk("rst_mid no_done", seen_done, 0);
    run('{"after_reset", 3, 1, 0, 0, 1, 4, 4, 1, 0, 1});
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/fuel_refill_controller.md
Name: fuel_refill_controller

Overview:
- Refuelling counterpart to the fuel gauge. The gauge consumes fuel; this block adds it.
- Accepts a refill request, runs a pump one litre at a time with a fixed cycle cost per litre, and clips delivery at tank capacity.
- Reports the updated tank level, which is fed back to the gauge's input_fuel.
- Sits beside the gauge. tank_level_in is wired from the gauge's remaining_fuel.

Parameters:
- TANK_CAP, 31, tank capacity in litres. Must be at most 31.
- PULSE_CYCLES, 4, clock cycles the pump runs per litre delivered. Must be at least 1.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  refill request strobe, sampled on rising clk edge
- req_litres  input  5  litres requested
- abort  input  1  stop pumping; discards any partial litre
- tank_level_in  input  5  current tank level, sampled at start
- busy  output  1  high while a refill is in progress (PUMP or DONE)
- pump_on  output  1  pump drive, high only in PUMP
- litre_pulse  output  1  one-cycle pulse per litre delivered
- tank_level  output  5  running tank level
- delivered  output  5  litres delivered in the current or last refill
- done  output  1  one-cycle completion strobe
- clipped  output  1  request exceeded free capacity; held until the next accepted start

Behaviour:
- Reset: every output is 0, state is IDLE and internal counters clear. Reset mid-refill aborts immediately with no done pulse.
- States: IDLE, PUMP, DONE. All outputs are registered.
- IDLE, start sampled high at edge E0:
  - tank_level <= tank_level_in; delivered <= 0.
  - room = TANK_CAP - tank_level_in, or 0 if tank_level_in >= TANK_CAP.
  - target = min(req_litres, room); clipped <= (req_litres > room).
  - If target == 0: go to DONE (done high in the cycle after E0; pump_on never rises).
  - Otherwise: go to PUMP, load the cycle counter with PULSE_CYCLES-1, remaining <= target.
- PUMP:
  - pump_on = 1.
  - Each edge with counter != 0: decrement the counter.
  - Edge with counter == 0 (litre complete):
    - litre_pulse high for the following cycle.
    - tank_level +1, delivered +1, remaining -1.
    - Counter reloads to PULSE_CYCLES-1.
    - If remaining was 1, go to DONE.
  - Litre k completes at edge E(k*PULSE_CYCLES).
  - done rises in the same cycle as the final litre_pulse: N*PULSE_CYCLES edges after E0.
- abort sampled high in PUMP:
  - Go to DONE at that edge; the partial litre is discarded.
  - If the same edge also completes a litre, that litre is counted (litre_pulse and increments occur), then DONE.
- DONE: done = 1 for exactly one cycle, pump_on = 0, then IDLE on the next edge.
- Handshake and holds:
  - start is ignored while busy. abort is ignored outside PUMP.
  - tank_level, delivered and clipped hold their values in IDLE.
- Arithmetic:
  - All arithmetic is 5-bit unsigned.
  - tank_level never exceeds TANK_CAP, guaranteed by the target computation.
- busy = (state != IDLE).

Test Plan:
- Nominal fill (PULSE_CYCLES=4): level_in=10, req=3, start at E0 -> litre_pulse after E4, E8, E12; done after E12; tank_level=13, delivered=3, clipped=0; pump_on high from after E0 through E12.
- Capacity clip: level_in=29, req=5 -> 2 litre_pulses, tank_level=31, delivered=2, clipped=1, done after E8.
- Full tank or zero request: level_in=31, req=4 (and separately level_in=10, req=0) -> done the cycle after E0, pump_on never high, delivered=0. clipped=1 in the first case, 0 in the second.
- Abort: level_in=0, req=5, abort high at E6 -> one litre_pulse (after E4), done after E6, delivered=1, tank_level=1. Also: abort coincident with E8 -> delivered=2.
- Reset mid-pump: reset asserted after E5 of a 5-litre fill -> all outputs 0 immediately; no done pulse; a new start after reset is accepted.
- Start while busy: second start at E3 with req=9 is ignored; the first refill completes unchanged.
